// File: rtl/gf180mcu_fd_sc_mcu7t5v0__setn_seq.sv
// ============================================================================
// gf180mcu_fd_sc_mcu7t5v0__setn_seq : round-robin preset sequencer for
// asynchronous-set flop banks (SETN width, then clock-enable recovery, ack).
// Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module gf180mcu_fd_sc_mcu7t5v0__setn_seq #(
  parameter int NREQ = 4,
  parameter int CW   = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [NREQ-1:0]          REQ,
  input  logic [CW-1:0]            WIDTH_CFG,
  input  logic [CW-1:0]            RECOV_CFG,
  output logic [NREQ-1:0]          SETN_O,
  output logic [NREQ-1:0]          CKEN_O,
  output logic [NREQ-1:0]          ACK,
  output logic                     BUSY,
  output logic [$clog2(NREQ)-1:0]  GRANT
);

  localparam int GW = $clog2(NREQ);

  typedef enum logic [2:0] {
    S_INIT_SET = 3'd0,
    S_INIT_REC = 3'd1,
    S_IDLE     = 3'd2,
    S_SET      = 3'd3,
    S_REC      = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t          r_state, w_state;
  logic [CW-1:0]   r_cnt, w_cnt;
  logic [CW-1:0]   r_recov, w_recov;
  logic [GW-1:0]   r_ptr, w_ptr;
  logic [GW-1:0]   r_grant, w_grant;
  logic [NREQ-1:0] r_setn, w_setn;
  logic [NREQ-1:0] r_cken, w_cken;
  logic [NREQ-1:0] r_ack, w_ack;
  logic            r_busy, w_busy;

  logic [CW-1:0]   w_wload, w_rload;
  logic            w_found;
  logic [GW-1:0]   w_pick;
  int              w_idx;
  logic            w_last;

  // A zero configuration still yields one full cycle of each phase.
  assign w_wload = (WIDTH_CFG == '0) ? CW'(1) : WIDTH_CFG;
  assign w_rload = (RECOV_CFG == '0) ? CW'(1) : RECOV_CFG;
  assign w_last  = (r_cnt <= CW'(1));

  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = 0;
    for (int i = 0; i < NREQ; i++) begin
      w_idx = int'(r_ptr) + i;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!w_found && REQ[w_idx]) begin
        w_found = 1'b1;
        w_pick  = GW'(w_idx);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_INIT_SET;
      r_cnt   <= w_wload;
      r_recov <= CW'(1);
      r_ptr   <= '0;
      r_grant <= '0;
      r_setn  <= '0;
      r_cken  <= '0;
      r_ack   <= '0;
      r_busy  <= 1'b1;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_recov <= w_recov;
      r_ptr   <= w_ptr;
      r_grant <= w_grant;
      r_setn  <= w_setn;
      r_cken  <= w_cken;
      r_ack   <= w_ack;
      r_busy  <= w_busy;
    end
  end

  always_comb begin
    w_state = r_state;
    w_cnt   = w_last ? r_cnt : r_cnt - 1'b1;
    w_recov = r_recov;
    w_ptr   = r_ptr;
    w_grant = r_grant;
    w_setn  = r_setn;
    w_cken  = r_cken;
    w_ack   = '0;
    w_busy  = r_busy;
    case (r_state)
      S_INIT_SET: begin
        if (w_last) begin
          w_setn  = '1;
          w_cnt   = w_rload;
          w_state = S_INIT_REC;
        end
      end
      S_INIT_REC: begin
        if (w_last) begin
          w_cken  = '1;
          w_busy  = 1'b0;
          w_state = S_IDLE;
        end
      end
      S_IDLE: begin
        w_cnt = r_cnt;
        if (w_found) begin
          w_grant         = w_pick;
          w_setn[w_pick]  = 1'b0;
          w_cken[w_pick]  = 1'b0;
          w_busy          = 1'b1;
          w_cnt           = w_wload;
          w_recov         = w_rload;
          w_state         = S_SET;
        end
      end
      S_SET: begin
        if (w_last) begin
          w_setn[r_grant] = 1'b1;
          w_cnt           = r_recov;
          w_state         = S_REC;
        end
      end
      S_REC: begin
        if (w_last) begin
          w_cken[r_grant] = 1'b1;
          w_ack[r_grant]  = 1'b1;
          w_ptr           = (r_grant == GW'(NREQ-1)) ? '0 : r_grant + 1'b1;
          w_state         = S_DONE;
        end
      end
      S_DONE: begin
        w_busy  = 1'b0;
        w_grant = '0;
        w_state = S_IDLE;
      end
      default: begin
        // Illegal encoding: re-preset every bank from scratch.
        w_setn  = '0;
        w_cken  = '0;
        w_busy  = 1'b1;
        w_grant = '0;
        w_cnt   = w_wload;
        w_state = S_INIT_SET;
      end
    endcase
  end

  assign SETN_O = r_setn;
  assign CKEN_O = r_cken;
  assign ACK    = r_ack;
  assign BUSY   = r_busy;
  assign GRANT  = r_grant;

  a_cken_needs_setn: assert property (@(posedge CLK) disable iff (RST)
    ((CKEN_O & ~SETN_O) == '0));

endmodule

`default_nettype wire

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__setn_seq.sv
// Randomized scoreboard bench for the SETN preset sequencer.
`default_nettype none
`timescale 1ns/1ps

module tb_gf180mcu_fd_sc_mcu7t5v0__setn_seq;

  localparam int NREQ = 4;
  localparam int CW   = 4;
  localparam int GW   = 2;
  localparam logic [NREQ-1:0] ALL = '1;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic [NREQ-1:0] REQ = '0;
  logic [CW-1:0]   WIDTH_CFG = '0;
  logic [CW-1:0]   RECOV_CFG = '0;
  logic [NREQ-1:0] SETN_O, CKEN_O, ACK;
  logic            BUSY;
  logic [GW-1:0]   GRANT;

  gf180mcu_fd_sc_mcu7t5v0__setn_seq #(.NREQ(NREQ), .CW(CW)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .WIDTH_CFG(WIDTH_CFG), .RECOV_CFG(RECOV_CFG),
    .SETN_O(SETN_O), .CKEN_O(CKEN_O), .ACK(ACK), .BUSY(BUSY), .GRANT(GRANT)
  );

  typedef struct {
    int g;
    int t;
    int w;
    int r;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   init_done = 1'b0;
  int   m_req = 0;
  int   m_ptr = 0;
  int   next_t = 0;

  always #5 CLK = ~CLK;

  // Edge index since reset release: edge 1 is the first posedge after RST falls.
  always @(posedge CLK or posedge RST) begin
    if (RST) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    int guard;
    guard = 0;
    while (cyc < n && guard < 20000) begin
      @(posedge CLK);
      #1;
      guard++;
    end
  endtask

  function automatic int rr(input int req, input int ptr);
    int b;
    for (int i = 0; i < NREQ; i++) begin
      b = (ptr + i) % NREQ;
      if (req[b]) return b;
    end
    return -1;
  endfunction

  // Monitor: compares every cycle against the oldest outstanding sequence.
  exp_t            me;
  int              ma;
  logic [NREQ-1:0] es, ec, ea;
  always @(negedge CLK) begin
    if (!RST && init_done) begin
      if (q.size() > 0 && cyc >= q[0].t) begin
        me = q[0];
        ma = me.t + me.w + me.r;
        es = ALL;
        ec = ALL;
        ea = '0;
        if (cyc < me.t + me.w) es[me.g] = 1'b0;
        if (cyc < ma)          ec[me.g] = 1'b0;
        if (cyc == ma)         ea[me.g] = 1'b1;
        chk("seq_setn", SETN_O, es);
        chk("seq_cken", CKEN_O, ec);
        chk("seq_ack", ACK, ea);
        chk("seq_grant", GRANT, me.g);
        chk("seq_busy", BUSY, 1);
        if (cyc >= ma) void'(q.pop_front());
      end else begin
        chk("idle_setn", SETN_O, ALL);
        chk("idle_cken", CKEN_O, ALL);
        chk("idle_ack", ACK, 0);
        chk("idle_busy", BUSY, 0);
        chk("idle_grant", GRANT, 0);
      end
    end
  end

  task automatic do_reset(input int w0, input int r0);
    int we, re;
    logic [NREQ-1:0] e;
    WIDTH_CFG = CW'(w0);
    RECOV_CFG = CW'(r0);
    REQ = '0;
    m_req = 0;
    m_ptr = 0;
    init_done = 1'b0;
    q.delete();
    RST = 1'b1;
    @(posedge CLK);
    #1;
    chk("rst_setn", SETN_O, 0);
    chk("rst_cken", CKEN_O, 0);
    chk("rst_ack", ACK, 0);
    chk("rst_busy", BUSY, 1);
    chk("rst_grant", GRANT, 0);
    RST = 1'b0;
    we = (w0 == 0) ? 1 : w0;
    re = (r0 == 0) ? 1 : r0;
    for (int k = 1; k <= we + re; k++) begin
      wait_cyc(k);
      e = (k >= we) ? ALL : {NREQ{1'b0}};
      chk("init_setn", SETN_O, e);
      e = (k >= we + re) ? ALL : {NREQ{1'b0}};
      chk("init_cken", CKEN_O, e);
      chk("init_busy", BUSY, (k < we + re) ? 1 : 0);
      chk("init_ack", ACK, 0);
    end
    next_t = we + re + 1;
    init_done = 1'b1;
  endtask

  // mode 0: drop REQ after ACK; 1: drop right after grant; 2: keep REQ high.
  task automatic issue_one(input int w, input int r, input int mode, input int midw, input int add);
    int t, g, we, re, a;
    exp_t e;
    if (next_t < cyc + 1) next_t = cyc + 1;
    t = next_t;
    wait_cyc(t - 1);
    WIDTH_CFG = CW'(w);
    RECOV_CFG = CW'(r);
    REQ = NREQ'(m_req);
    g  = rr(m_req, m_ptr);
    we = (w == 0) ? 1 : w;
    re = (r == 0) ? 1 : r;
    a  = t + we + re;
    e.g = g; e.t = t; e.w = we; e.r = re;
    q.push_back(e);
    wait_cyc(t);
    WIDTH_CFG = CW'(midw);
    RECOV_CFG = CW'($urandom_range(0, 15));
    if (mode == 1) m_req = m_req & ~(1 << g);
    if (add >= 0 && add != g) m_req = m_req | (1 << add);
    REQ = NREQ'(m_req);
    wait_cyc(a);
    if (mode == 0) begin
      m_req = m_req & ~(1 << g);
      REQ = NREQ'(m_req);
    end
    m_ptr = (g + 1) % NREQ;
    next_t = a + 2;
  endtask

  initial begin : main
    int ng, mode, add, t;
    exp_t e;

    do_reset(3, 2);

    m_req = 4'b0100;
    issue_one(2, 1, 0, 2, -1);
    m_req = 4'b1000;
    issue_one(0, 0, 0, 0, -1);

    // All four held: order 0,1,2,3,0 then drain 1,2,3.
    m_req = 4'b1111;
    for (int i = 0; i < 4; i++) issue_one(1, 2, 2, 3, -1);
    while (m_req != 0) issue_one(2, 1, 0, 5, -1);

    m_req = 4'b0010;
    issue_one(2, 1, 1, 7, -1);
    m_req = 4'b0001;
    issue_one(15, 15, 0, 0, -1);

    for (int rnd = 0; rnd < 25; rnd++) begin
      ng = 0;
      m_req = int'($urandom_range(1, 15));
      while (m_req != 0) begin
        mode = int'($urandom_range(0, 3));
        if (mode == 3) mode = 2;
        else if (mode == 2) mode = 0;
        if (ng >= 8) mode = 0;
        add = -1;
        if (ng < 8 && $urandom_range(0, 3) == 0) add = int'($urandom_range(0, NREQ-1));
        issue_one(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), mode,
                  int'($urandom_range(0, 15)), add);
        ng++;
      end
      if ($urandom_range(0, 1) == 1) wait_cyc(cyc + int'($urandom_range(1, 4)));
    end

    // Reset during the recovery phase of bank 3.
    if (next_t < cyc + 1) next_t = cyc + 1;
    t = next_t;
    wait_cyc(t - 1);
    WIDTH_CFG = 4'd2;
    RECOV_CFG = 4'd4;
    m_req = 4'b1000;
    REQ = 4'b1000;
    e.g = 3; e.t = t; e.w = 2; e.r = 4;
    q.push_back(e);
    wait_cyc(t + 3);
    RST = 1'b1;
    init_done = 1'b0;
    #1;
    chk("midrst_setn", SETN_O, 0);
    chk("midrst_cken", CKEN_O, 0);
    chk("midrst_ack", ACK, 0);
    chk("midrst_busy", BUSY, 1);
    chk("midrst_grant", GRANT, 0);
    do_reset(4, 3);

    m_req = 4'b0101;
    while (m_req != 0) issue_one(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0, 9, -1);

    wait_cyc(cyc + 3);
    chk("sb_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
